// File: rtl/sccb_responder_if.sv
// Register-file side of the SCCB responder: address/data latches, write and read strobes.
// The responder uses the master modport; the register file uses the slave modport.
interface sccb_responder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic                  reg_we;
  logic                  reg_re;
  logic [DATA_WIDTH-1:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/sccb_responder.sv
// SCCB target: decodes start/stop, device/sub-address and data bytes, drives ACK and read bits.
// Define SCCB_RESP_AUTOINC_EN for burst writes/reads with auto-incrementing sub-address.
module sccb_responder #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h42,
  parameter int          DATA_WIDTH     = 8,
  parameter int          ADDR_WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             scl,
  inout  wire              sda,
  sccb_responder_if.master rif,
  output logic             busy,
  output logic             direction
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_SUB_ADDR, S_SUB_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  state_t                state_q;
  logic [2:0]            bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  rw_q;
  logic                  re_dly_q;
  logic                  scl_q, scl_d, sda_q, sda_d;
  logic                  sda_out_en_q, out_sda_q;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] reg_addr_q;
  logic [DATA_WIDTH-1:0] reg_wdata_q;
  logic                  reg_we_q, reg_re_q;

  logic                  rise, start_cond, stop_cond, last_bit;
  logic [DATA_WIDTH-1:0] byte_in;

  always_comb begin
    rise       = scl_q & ~scl_d;
    start_cond = scl_q & scl_d & sda_d & ~sda_q;
    stop_cond  = scl_q & scl_d & ~sda_d & sda_q;
    last_bit   = (bit_cnt_q == 3'd7);
    byte_in    = {shift_q[DATA_WIDTH-2:0], sda_q};
  end

  // Bus idles high, so the sampling stages reset to 1 to avoid a false start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_q <= 1'b1;
      scl_d <= 1'b1;
      sda_q <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= scl;
      scl_d <= scl_q;
      sda_q <= sda;
      sda_d <= sda_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= '0;
      rw_q         <= 1'b0;
      re_dly_q     <= 1'b0;
      sda_out_en_q <= 1'b0;
      out_sda_q    <= 1'b1;
      busy_q       <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;
      re_dly_q <= reg_re_q;
`ifdef SCCB_RESP_AUTOINC_EN
      // Advance only after the write strobe so reg_addr stays valid during it.
      if (reg_we_q) reg_addr_q <= reg_addr_q + ADDR_WIDTH'(1);
`endif
      if (start_cond) begin
        state_q      <= S_DEV_ADDR;
        bit_cnt_q    <= 3'd0;
        sda_out_en_q <= 1'b0;
        out_sda_q    <= 1'b1;
        busy_q       <= 1'b1;
      end else if (stop_cond) begin
        state_q      <= S_IDLE;
        bit_cnt_q    <= 3'd0;
        sda_out_en_q <= 1'b0;
        out_sda_q    <= 1'b1;
        busy_q       <= 1'b0;
      end else if (state_q == S_RD_DATA && re_dly_q) begin
        // Register file answered the read strobe: put the MSB on the wire.
        shift_q      <= rif.reg_rdata;
        out_sda_q    <= rif.reg_rdata[DATA_WIDTH-1];
        sda_out_en_q <= 1'b1;
        bit_cnt_q    <= 3'd0;
      end else if (rise) begin
        case (state_q)
          S_IDLE, S_IGNORE: begin
            sda_out_en_q <= 1'b0;
            out_sda_q    <= 1'b1;
          end
          S_DEV_ADDR: begin
            shift_q   <= byte_in;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              if (byte_in[DATA_WIDTH-1:1] == DEVICE_ADDRESS) begin
                rw_q         <= byte_in[0];
                sda_out_en_q <= 1'b1;
                out_sda_q    <= 1'b0;
                state_q      <= S_DEV_ACK;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
          S_DEV_ACK: begin
            bit_cnt_q <= 3'd0;
            if (!rw_q) begin
              sda_out_en_q <= 1'b0;
              out_sda_q    <= 1'b1;
              state_q      <= S_SUB_ADDR;
            end else begin
              reg_re_q <= 1'b1;
              state_q  <= S_RD_DATA;
            end
          end
          S_SUB_ADDR: begin
            shift_q   <= byte_in;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              reg_addr_q   <= byte_in;
              sda_out_en_q <= 1'b1;
              out_sda_q    <= 1'b0;
              state_q      <= S_SUB_ACK;
            end
          end
          S_SUB_ACK: begin
            sda_out_en_q <= 1'b0;
            out_sda_q    <= 1'b1;
            bit_cnt_q    <= 3'd0;
            state_q      <= S_WR_DATA;
          end
          S_WR_DATA: begin
            shift_q   <= byte_in;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              reg_wdata_q  <= byte_in;
              sda_out_en_q <= 1'b1;
              out_sda_q    <= 1'b0;
              state_q      <= S_WR_ACK;
            end
          end
          S_WR_ACK: begin
            reg_we_q     <= 1'b1;
            sda_out_en_q <= 1'b0;
            out_sda_q    <= 1'b1;
            bit_cnt_q    <= 3'd0;
`ifdef SCCB_RESP_AUTOINC_EN
            state_q      <= S_WR_DATA;
`else
            state_q      <= S_IGNORE;
`endif
          end
          S_RD_DATA: begin
            if (last_bit) begin
              sda_out_en_q <= 1'b0;
              out_sda_q    <= 1'b1;
              state_q      <= S_RD_ACK;
            end else begin
              shift_q   <= shift_q << 1;
              out_sda_q <= shift_q[DATA_WIDTH-2];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          S_RD_ACK: begin
            bit_cnt_q <= 3'd0;
            if (!sda_q) begin
              reg_re_q <= 1'b1;
`ifdef SCCB_RESP_AUTOINC_EN
              reg_addr_q <= reg_addr_q + ADDR_WIDTH'(1);
`endif
              state_q  <= S_RD_DATA;
            end else begin
              state_q <= S_IGNORE;
            end
          end
          default: begin
            sda_out_en_q <= 1'b0;
            out_sda_q    <= 1'b1;
            state_q      <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign sda           = sda_out_en_q ? out_sda_q : 1'bz;
  assign rif.reg_addr  = reg_addr_q;
  assign rif.reg_wdata = reg_wdata_q;
  assign rif.reg_we    = reg_we_q;
  assign rif.reg_re    = reg_re_q;
  assign busy          = busy_q;
  assign direction     = sda_out_en_q;

endmodule
